fetch_stage: RTL and testbench

Pipeline Fetch stage plus IF/ID register for the 5-stage RISC-V core. Owns the PC, issues word fetches to a variable-latency instruction memory over a request/response handshake, and presents instrD/PCD/PCPlus4D to Decode. Honours stall and flush from the hazard unit and PC redirects from Execute, dropping any in-flight stale fetch.

---
 rtl/fetch_stage.sv | 137 +++++++++++++
 tb/tb_fetch_stage.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, keeps one instruction fetch in flight and drives the IF/ID register.
// Optional build macro FETCH_PERF_CNT_EN adds fetch_cnt/drop_cnt performance counters.
module fetch_stage #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic                     imem_ready,
    input  logic                     imem_rvalid,
    input  logic [DATA_WIDTH-1:0]    imem_rdata,
    input  logic                     StallD,
    input  logic                     FlushD,
    input  logic                     PCSrcE,
    input  logic [ADDRESS_WIDTH-1:0] PCTargetE,
    output logic [DATA_WIDTH-1:0]    instrD,
    output logic [ADDRESS_WIDTH-1:0] PCD,
    output logic [ADDRESS_WIDTH-1:0] PCPlus4D,
    output logic                     validD
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]              fetch_cnt,
    output logic [31:0]              drop_cnt
`endif
);

    localparam logic [DATA_WIDTH-1:0]    NOP      = DATA_WIDTH'(32'h0000_0013);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_INC = ADDRESS_WIDTH'(4);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP, S_SKID} state_t;

    state_t                   state;
    logic [ADDRESS_WIDTH-1:0] pc_q;
    logic [ADDRESS_WIDTH-1:0] req_pc;
    logic [ADDRESS_WIDTH-1:0] skid_pc;
    logic [DATA_WIDTH-1:0]    skid_instr;

    logic                     handshake;
    logic                     resp_load;
    logic                     skid_load;
    logic                     skid_capture;
    logic                     resp_drop;
    logic                     if_load;
    logic [ADDRESS_WIDTH-1:0] load_pc;
    logic [DATA_WIDTH-1:0]    load_instr;

    assign imem_req  = (state == S_REQ) && !PCSrcE;
    assign imem_addr = pc_q;
    assign handshake = imem_req && imem_ready;

    // A redirect in the response cycle discards the data rather than loading or parking it.
    assign resp_load    = (state == S_WAIT) && imem_rvalid && !PCSrcE && !StallD;
    assign skid_capture = (state == S_WAIT) && imem_rvalid && !PCSrcE && StallD;
    assign skid_load    = (state == S_SKID) && !PCSrcE && !StallD;
    assign resp_drop    = imem_rvalid && (((state == S_WAIT) && PCSrcE) || (state == S_DROP));
    assign if_load      = resp_load || skid_load;
    assign load_pc      = skid_load ? skid_pc : req_pc;
    assign load_instr   = skid_load ? skid_instr : imem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_REQ;
            pc_q     <= RESET_PC;
            instrD   <= NOP;
            PCD      <= '0;
            PCPlus4D <= '0;
            validD   <= 1'b0;
        end else begin
            if (PCSrcE) begin
                pc_q <= PCTargetE;
            end else if (handshake) begin
                pc_q <= pc_q + ADDR_INC;
            end

            case (state)
                S_REQ:  if (handshake) state <= S_WAIT;
                S_WAIT: begin
                    if (PCSrcE) begin
                        state <= imem_rvalid ? S_REQ : S_DROP;
                    end else if (imem_rvalid) begin
                        state <= StallD ? S_SKID : S_REQ;
                    end
                end
                // The stale response retires the drop even if another redirect lands with it.
                S_DROP: if (imem_rvalid) state <= S_REQ;
                S_SKID: if (PCSrcE || !StallD) state <= S_REQ;
                default: state <= S_REQ;
            endcase

            if (FlushD || PCSrcE) begin
                validD <= 1'b0;
                instrD <= NOP;
            end else if (!StallD) begin
                if (if_load) begin
                    instrD   <= load_instr;
                    PCD      <= load_pc;
                    PCPlus4D <= load_pc + ADDR_INC;
                    validD   <= 1'b1;
                end else begin
                    validD <= 1'b0;
                    instrD <= NOP;
                end
            end
        end
    end

    // Data-only registers; their validity is carried by the FSM state.
    always_ff @(posedge clk) begin
        if (handshake) begin
            req_pc <= pc_q;
        end
        if (skid_capture) begin
            skid_instr <= imem_rdata;
            skid_pc    <= req_pc;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (if_load && !FlushD) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (resp_drop) begin
                drop_cnt <= drop_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table, reset corner sequence and randomized run of fetch_stage
// against a transaction-level reference model and a variable-latency memory.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        StallD;
    logic        FlushD;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] instrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        validD;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] drop_cnt;
`endif

    fetch_stage #(
        .ADDRESS_WIDTH(32),
        .DATA_WIDTH   (32),
        .RESET_PC     (32'h0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .instrD     (instrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .validD     (validD)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt  (fetch_cnt),
        .drop_cnt   (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int lat      = 1;
    bit spurious_en = 1'b0;

    // Memory: responds to each accepted request 'lat' cycles later, in order.
    typedef struct {
        int          due;
        logic [31:0] data;
    } resp_t;
    resp_t mq[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'h0010_0113;
        return {a[23:0], 8'h13};
    endfunction

    // Values seen at the negedge before each active edge.
    bit          sm_rst, sm_ready, sm_rvalid, sm_stall, sm_flush, sm_pcsrc, sm_req;
    logic [31:0] sm_rdata, sm_target, sm_addr;

    // Reference model: next fetch PC, the single outstanding fetch, a parked instruction, IF/ID.
    logic [31:0] m_pc, out_pc, held_instr, held_pc;
    bit          has_out, out_stale, has_held;
    logic [31:0] e_instr, e_pc, e_pc4;
    bit          e_valid;

    task automatic model_reset();
        m_pc     = 32'h0;
        has_out  = 1'b0;
        out_stale = 1'b0;
        has_held = 1'b0;
        e_instr  = NOP;
        e_pc     = 32'h0;
        e_pc4    = 32'h0;
        e_valid  = 1'b0;
    endtask

    task automatic model_step();
        bit          accept;
        bit          fresh;
        bit          cand;
        logic [31:0] c_instr;
        logic [31:0] c_pc;
        if (sm_rst) begin
            model_reset();
            return;
        end
        accept  = !has_out && !has_held && !sm_pcsrc && sm_ready;
        fresh   = sm_rvalid && has_out && !out_stale && !sm_pcsrc;
        cand    = 1'b0;
        c_instr = NOP;
        c_pc    = 32'h0;
        if (sm_rvalid && has_out) has_out = 1'b0;
        else if (sm_pcsrc && has_out) out_stale = 1'b1;
        if (sm_pcsrc) begin
            has_held = 1'b0;
            m_pc     = sm_target;
        end
        if (has_held) begin
            cand = 1'b1; c_instr = held_instr; c_pc = held_pc;
        end else if (fresh) begin
            cand = 1'b1; c_instr = sm_rdata; c_pc = out_pc;
        end
        if (sm_flush || sm_pcsrc) begin
            e_valid = 1'b0; e_instr = NOP;
        end else if (!sm_stall) begin
            if (cand) begin
                e_valid = 1'b1; e_instr = c_instr; e_pc = c_pc; e_pc4 = c_pc + 32'd4;
            end else begin
                e_valid = 1'b0; e_instr = NOP;
            end
        end
        if (!sm_stall && cand) begin
            has_held = 1'b0;
        end else if (sm_stall && fresh) begin
            has_held = 1'b1; held_instr = sm_rdata; held_pc = out_pc;
        end
        if (accept) begin
            has_out = 1'b1; out_stale = 1'b0; out_pc = m_pc; m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: sample at negedge, advance model and memory just after the rising edge.
    task automatic tick();
        resp_t r;
        @(negedge clk);
        sm_rst = rst; sm_ready = imem_ready; sm_rvalid = imem_rvalid; sm_rdata = imem_rdata;
        sm_stall = StallD; sm_flush = FlushD; sm_pcsrc = PCSrcE; sm_target = PCTargetE;
        sm_req = imem_req; sm_addr = imem_addr;
        @(posedge clk);
        #1;
        cyc++;
        model_step();
        if (!sm_rst && sm_req && sm_ready) begin
            r.due  = cyc - 1 + lat;
            r.data = mem_word(sm_addr);
            mq.push_back(r);
        end
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mq[0].data;
            void'(mq.pop_front());
        end else if (spurious_en && mq.size() == 0 && $urandom_range(0, 7) == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = $urandom;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
    endtask

    task automatic model_cycle();
        bit          x_req;
        logic [31:0] x_addr;
        x_req  = !has_out && !has_held && !PCSrcE;
        x_addr = m_pc;
        tick();
        chk("imem_req", {31'b0, sm_req}, {31'b0, x_req});
        chk("imem_addr", sm_addr, x_addr);
        chk("validD", {31'b0, validD}, {31'b0, e_valid});
        chk("instrD", instrD, e_instr);
        chk("PCD", PCD, e_pc);
        chk("PCPlus4D", PCPlus4D, e_pc4);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_instrD"}, instrD, NOP);
        chk({tag, "_PCD"}, PCD, 32'h0);
        chk({tag, "_PCPlus4D"}, PCPlus4D, 32'h0);
        chk({tag, "_validD"}, {31'b0, validD}, 32'h0);
        chk({tag, "_imem_req"}, {31'b0, imem_req}, 32'h1);
        chk({tag, "_imem_addr"}, imem_addr, 32'h0);
    endtask

    typedef struct {
        bit          ready, stall, flush, pcsrc;
        logic [31:0] target;
        int          lat;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_instr, e_pc, e_pc4;
    } vec_t;

    function automatic vec_t row(input bit rd, input bit st, input bit pcs, input logic [31:0] tg,
                                 input int l, input bit erq, input logic [31:0] ead,
                                 input bit ev, input logic [31:0] ei, input logic [31:0] ep,
                                 input logic [31:0] ep4);
        vec_t v;
        v.ready = rd; v.stall = st; v.flush = 1'b0; v.pcsrc = pcs; v.target = tg; v.lat = l;
        v.e_req = erq; v.e_addr = ead; v.e_valid = ev; v.e_instr = ei; v.e_pc = ep; v.e_pc4 = ep4;
        return v;
    endfunction

    initial begin
        vec_t tbl[$];
        // Straight fetches, a 3-cycle stall over the 0x8 response, redirect while waiting,
        // redirect coinciding with the response, then memory not ready for 5 cycles.
        tbl.push_back(row(1, 0, 0, 0,     1, 1, 32'h00, 0, NOP,          32'h0,  32'h0));
        tbl.push_back(row(1, 0, 0, 0,     1, 0, 32'h04, 1, 32'h00500093, 32'h0,  32'h4));
        tbl.push_back(row(1, 0, 0, 0,     1, 1, 32'h04, 0, NOP,          32'h0,  32'h4));
        tbl.push_back(row(1, 0, 0, 0,     1, 0, 32'h08, 1, 32'h00100113, 32'h4,  32'h8));
        tbl.push_back(row(1, 1, 0, 0,     1, 1, 32'h08, 1, 32'h00100113, 32'h4,  32'h8));
        tbl.push_back(row(1, 1, 0, 0,     1, 0, 32'h0C, 1, 32'h00100113, 32'h4,  32'h8));
        tbl.push_back(row(1, 1, 0, 0,     1, 0, 32'h0C, 1, 32'h00100113, 32'h4,  32'h8));
        tbl.push_back(row(1, 0, 0, 0,     1, 0, 32'h0C, 1, 32'h00000813, 32'h8,  32'hC));
        tbl.push_back(row(1, 0, 0, 0,     3, 1, 32'h0C, 0, NOP,          32'h8,  32'hC));
        tbl.push_back(row(1, 0, 0, 0,     3, 0, 32'h10, 0, NOP,          32'h8,  32'hC));
        tbl.push_back(row(1, 0, 0, 0,     3, 0, 32'h10, 0, NOP,          32'h8,  32'hC));
        tbl.push_back(row(1, 0, 0, 0,     3, 0, 32'h10, 1, 32'h00000C13, 32'hC,  32'h10));
        tbl.push_back(row(1, 0, 0, 0,     3, 1, 32'h10, 0, NOP,          32'hC,  32'h10));
        tbl.push_back(row(1, 0, 1, 32'h40, 3, 0, 32'h14, 0, NOP,          32'hC,  32'h10));
        tbl.push_back(row(1, 0, 0, 0,     3, 0, 32'h40, 0, NOP,          32'hC,  32'h10));
        tbl.push_back(row(1, 0, 0, 0,     3, 0, 32'h40, 0, NOP,          32'hC,  32'h10));
        tbl.push_back(row(1, 0, 0, 0,     2, 1, 32'h40, 0, NOP,          32'hC,  32'h10));
        tbl.push_back(row(1, 0, 0, 0,     2, 0, 32'h44, 0, NOP,          32'hC,  32'h10));
        tbl.push_back(row(1, 0, 1, 32'h40, 2, 0, 32'h44, 0, NOP,          32'hC,  32'h10));
        for (int i = 0; i < 5; i++)
            tbl.push_back(row(0, 0, 0, 0, 1, 1, 32'h40, 0, NOP,          32'hC,  32'h10));
        tbl.push_back(row(1, 0, 0, 0,     1, 1, 32'h40, 0, NOP,          32'hC,  32'h10));
        tbl.push_back(row(0, 0, 0, 0,     1, 0, 32'h44, 1, 32'h00004013, 32'h40, 32'h44));
        tbl.push_back(row(0, 0, 0, 0,     1, 1, 32'h44, 0, NOP,          32'h40, 32'h44));

        rst = 1'b1; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
        model_reset();
        tick();
        tick();
        chk_reset_values("reset");
        rst = 1'b0;

        foreach (tbl[i]) begin
            imem_ready = tbl[i].ready; StallD = tbl[i].stall; FlushD = tbl[i].flush;
            PCSrcE = tbl[i].pcsrc; PCTargetE = tbl[i].target; lat = tbl[i].lat;
            tick();
            chk($sformatf("vec%0d_imem_req", i), {31'b0, sm_req}, {31'b0, tbl[i].e_req});
            chk($sformatf("vec%0d_imem_addr", i), sm_addr, tbl[i].e_addr);
            chk($sformatf("vec%0d_validD", i), {31'b0, validD}, {31'b0, tbl[i].e_valid});
            chk($sformatf("vec%0d_instrD", i), instrD, tbl[i].e_instr);
            chk($sformatf("vec%0d_PCD", i), PCD, tbl[i].e_pc);
            chk($sformatf("vec%0d_PCPlus4D", i), PCPlus4D, tbl[i].e_pc4);
        end

        // Asynchronous reset in the middle of a wait; the stale response then lands in S_REQ.
        imem_ready = 1'b1; lat = 3;
        model_cycle();
        imem_ready = 1'b0;
        #1 rst = 1'b1;
        #1 chk_reset_values("async_rst");
        tick();
        tick();
        rst = 1'b0;
        model_cycle();
        imem_ready = 1'b1; lat = 1;
        model_cycle();
        imem_ready = 1'b0;
        model_cycle();
        chk("post_rst_instrD", instrD, 32'h0050_0093);
        chk("post_rst_PCD", PCD, 32'h0);
        chk("post_rst_validD", {31'b0, validD}, 32'h1);

        spurious_en = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            imem_ready = ($urandom_range(0, 3) != 0);
            StallD     = ($urandom_range(0, 3) == 0);
            FlushD     = ($urandom_range(0, 9) == 0);
            PCSrcE     = ($urandom_range(0, 11) == 0);
            PCTargetE  = 32'($urandom_range(0, 255)) << 2;
            lat        = $urandom_range(1, 3);
            model_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
